// File: rtl/cpu_clk_ctrl_if.sv
// Control/observation bundle between the CPU clock controller and the rest of the core.
// master drives mode, step, breakpoint and bus-snoop inputs; slave is the controller.
interface cpu_clk_ctrl_if #(
    parameter int DIV_WIDTH  = 17,
    parameter int ADDR_WIDTH = 16,
    parameter int CYC_WIDTH  = 32
);
    logic [1:0]            mode;
    logic [DIV_WIDTH-1:0]  div_tc;
    logic                  step_req;
    logic                  resume;
    logic                  bp_en;
    logic [ADDR_WIDTH-1:0] bp_addr;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  fetch;
    logic                  cpu_ce;
    logic                  halted;
    logic                  bp_hit;
    logic [CYC_WIDTH-1:0]  cycle_count;

    modport master (
        output mode, div_tc, step_req, resume, bp_en, bp_addr, addr, fetch,
        input  cpu_ce, halted, bp_hit, cycle_count
    );

    modport slave (
        input  mode, div_tc, step_req, resume, bp_en, bp_addr, addr, fetch,
        output cpu_ce, halted, bp_hit, cycle_count
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: FULL/DIV/STEP/HOLD modes, opcode-fetch breakpoint, enabled-cycle counter.
// All outputs registered (one clock from inputs); step pulses land STEP_SYNC+1 clocks after step_req; no backpressure.
module cpu_clk_ctrl #(
    parameter int DIV_WIDTH  = 17,
    parameter int ADDR_WIDTH = 16,
    parameter int CYC_WIDTH  = 32,
    parameter int STEP_SYNC  = 2
) (
    input logic           clk,
    input logic           rst,
    cpu_clk_ctrl_if.slave bus
);
    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_DIV  = 2'd1;
    localparam logic [1:0] MODE_STEP = 2'd2;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_BRK = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [STEP_SYNC-1:0]   sync_q;
    logic                   edge_prev_q;
    logic                   step_edge_q;
    logic                   cpu_ce_q, cpu_ce_d;
    logic                   halted_q, halted_d;
    logic                   bp_hit_q, bp_hit_d;
    logic [CYC_WIDTH-1:0]   cyc_q;
    logic                   bp_match;

    // Synchroniser chain followed by a registered rising-edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '0;
            edge_prev_q <= 1'b0;
            step_edge_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[STEP_SYNC-2:0], bus.step_req};
            edge_prev_q <= sync_q[STEP_SYNC-1];
            step_edge_q <= sync_q[STEP_SYNC-1] & ~edge_prev_q;
        end
    end

    assign bp_match = cpu_ce_q & bus.fetch & bus.bp_en & (bus.addr == bus.bp_addr);

    // Divider count is held at zero outside RUN/DIV, so any mode change restarts it.
    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        cpu_ce_d = 1'b0;
        bp_hit_d = bp_match;
        case (state_q)
            ST_RUN: begin
                if (bp_match) begin
                    state_d = ST_BRK;
                end else begin
                    case (bus.mode)
                        MODE_FULL: cpu_ce_d = 1'b1;
                        MODE_DIV: begin
                            if (div_q == bus.div_tc) begin
                                cpu_ce_d = 1'b1;
                            end else begin
                                div_d = div_q + DIV_WIDTH'(1);
                            end
                        end
                        MODE_STEP: cpu_ce_d = step_edge_q;
                        default:   cpu_ce_d = 1'b0;
                    endcase
                end
            end
            ST_BRK: begin
                if (bus.resume) begin
                    state_d = ST_RUN;
                end else begin
                    cpu_ce_d = step_edge_q;
                end
            end
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_BRK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            div_q    <= '0;
            cpu_ce_q <= 1'b0;
            halted_q <= 1'b0;
            bp_hit_q <= 1'b0;
            cyc_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cpu_ce_q <= cpu_ce_d;
            halted_q <= halted_d;
            bp_hit_q <= bp_hit_d;
            cyc_q    <= cyc_q + CYC_WIDTH'(cpu_ce_q);
        end
    end

    assign bus.cpu_ce      = cpu_ce_q;
    assign bus.halted      = halted_q;
    assign bus.bp_hit      = bp_hit_q;
    assign bus.cycle_count = cyc_q;
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Scoreboarded bench for cpu_clk_ctrl: directed scenarios followed by randomized traffic.
module tb_cpu_clk_ctrl;
    localparam int DW  = 17;
    localparam int AW  = 16;
    localparam int CW  = 4;
    localparam int SS  = 2;

    logic clk;
    logic rst;

    cpu_clk_ctrl_if #(.DIV_WIDTH(DW), .ADDR_WIDTH(AW), .CYC_WIDTH(CW)) bus_if ();

    cpu_clk_ctrl #(
        .DIV_WIDTH (DW),
        .ADDR_WIDTH(AW),
        .CYC_WIDTH (CW),
        .STEP_SYNC (SS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct packed {
        logic          ce;
        logic          halted;
        logic          bp;
        logic [CW-1:0] cc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mod_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: step_req sample history and abstract counters.
    int   sh[$];
    bit   m_ce, m_halt, m_bp, sf, hit, nce;
    int   m_cc, m_div;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic window(input int n, output int ce_n, output int first_pos,
                          output int halt_low, output int bp_n);
        ce_n = 0; first_pos = 0; halt_low = 0; bp_n = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus_if.cpu_ce) begin
                ce_n++;
                if (first_pos == 0) first_pos = i;
            end
            if (!bus_if.halted) halt_low++;
            if (bus_if.bp_hit) bp_n++;
        end
    endtask

    // Model: a step pulse is due when the step_req sample SS+1 edges ago was
    // high and the one before it low; DIV fires on every (div_tc+1)-th clock.
    initial begin
        for (int i = 0; i < SS + 3; i++) sh.push_back(0);
        m_ce = 0; m_halt = 0; m_bp = 0; m_cc = 0; m_div = 0;
        forever begin
            @(posedge clk);
            sh.push_back(rst ? 0 : int'(bus_if.step_req));
            sh.delete(0);
            if (rst) begin
                foreach (sh[i]) sh[i] = 0;
                m_ce = 0; m_halt = 0; m_bp = 0; m_cc = 0; m_div = 0;
            end else begin
                sf   = (sh[1] == 1) && (sh[0] == 0);
                hit  = m_ce && bus_if.fetch && bus_if.bp_en && (bus_if.addr == bus_if.bp_addr);
                m_cc = (m_cc + int'(m_ce)) % (1 << CW);
                m_bp = hit;
                if (m_halt) begin
                    nce = sf && !bus_if.resume;
                    if (bus_if.resume) m_halt = 0;
                    m_div = 0;
                end else if (hit) begin
                    nce = 0; m_halt = 1; m_div = 0;
                end else begin
                    case (bus_if.mode)
                        2'd0: begin nce = 1; m_div = 0; end
                        2'd1: begin
                            nce = ((m_div + 1) % (int'(bus_if.div_tc) + 1)) == 0;
                            m_div++;
                        end
                        2'd2: begin nce = sf; m_div = 0; end
                        default: begin nce = 0; m_div = 0; end
                    endcase
                end
                m_ce = nce;
            end
            mod_e.ce     = m_ce;
            mod_e.halted = m_halt;
            mod_e.bp     = m_bp;
            mod_e.cc     = CW'(m_cc);
            exp_q.push_back(mod_e);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_cpu_ce", int'(bus_if.cpu_ce), int'(mon_e.ce));
                check("sb_halted", int'(bus_if.halted), int'(mon_e.halted));
                check("sb_bp_hit", int'(bus_if.bp_hit), int'(mon_e.bp));
                check("sb_cycle_count", int'(bus_if.cycle_count), int'(mon_e.cc));
            end
        end
    end

    int ce_n, pos, hl, bp_n, nm;

    initial begin
        rst             = 1'b1;
        bus_if.mode     = 2'd0;
        bus_if.div_tc   = '0;
        bus_if.step_req = 1'b0;
        bus_if.resume   = 1'b0;
        bus_if.bp_en    = 1'b0;
        bus_if.bp_addr  = 16'hC003;
        bus_if.addr     = '0;
        bus_if.fetch    = 1'b0;

        // Reset then FULL
        tick(3);
        check("reset_ce", int'(bus_if.cpu_ce), 0);
        check("reset_halted", int'(bus_if.halted), 0);
        check("reset_cc", int'(bus_if.cycle_count), 0);
        rst = 1'b0;
        tick(11);
        check("full_cc10", int'(bus_if.cycle_count), 10);
        check("full_ce", int'(bus_if.cpu_ce), 1);

        // DIV by 5, then back to FULL mid-count
        bus_if.mode   = 2'd1;
        bus_if.div_tc = DW'(4);
        window(25, ce_n, pos, hl, bp_n);
        check("div5_pulses", ce_n, 5);
        bus_if.mode = 2'd0;
        tick(1);
        check("div_to_full_ce", int'(bus_if.cpu_ce), 1);

        // STEP latency and single pulse per edge
        rst = 1'b1;
        bus_if.mode = 2'd2;
        tick(2);
        rst = 1'b0;
        tick(5);
        bus_if.step_req = 1'b1;
        window(20, ce_n, pos, hl, bp_n);
        check("step1_pulses", ce_n, 1);
        check("step1_latency", pos, SS + 2);
        bus_if.step_req = 1'b0;
        tick(5);
        bus_if.step_req = 1'b1;
        window(10, ce_n, pos, hl, bp_n);
        check("step2_pulses", ce_n, 1);
        check("step_cc2", int'(bus_if.cycle_count), 2);
        bus_if.step_req = 1'b0;

        // Breakpoint in FULL
        bus_if.mode  = 2'd0;
        bus_if.bp_en = 1'b1;
        tick(2);
        bus_if.fetch = 1'b1;
        bus_if.addr  = 16'hC003;
        tick(1);
        check("bp_halted", int'(bus_if.halted), 1);
        check("bp_hit_pulse", int'(bus_if.bp_hit), 1);
        check("bp_ce_off", int'(bus_if.cpu_ce), 0);
        bus_if.fetch = 1'b0;
        bus_if.addr  = '0;
        window(50, ce_n, pos, hl, bp_n);
        check("brk_ce_count", ce_n, 0);
        check("brk_bp_count", bp_n, 0);
        check("brk_halt_low", hl, 0);

        // Step inside BRK, then resume colliding with a step edge
        bus_if.step_req = 1'b1;
        window(8, ce_n, pos, hl, bp_n);
        check("brk_step_pulses", ce_n, 1);
        check("brk_step_halt_low", hl, 0);
        bus_if.step_req = 1'b0;
        tick(5);
        bus_if.step_req = 1'b1;
        tick(3);
        bus_if.resume = 1'b1;
        tick(1);
        check("resume_halted", int'(bus_if.halted), 0);
        check("resume_no_step", int'(bus_if.cpu_ce), 0);
        bus_if.resume = 1'b0;
        tick(1);
        check("resume_full_ce", int'(bus_if.cpu_ce), 1);
        bus_if.step_req = 1'b0;

        // Reset while halted, then cycle counter wrap
        bus_if.fetch = 1'b1;
        bus_if.addr  = 16'hC003;
        tick(1);
        bus_if.fetch = 1'b0;
        bus_if.addr  = '0;
        check("rehalt", int'(bus_if.halted), 1);
        rst = 1'b1;
        tick(1);
        check("rst_brk_halted", int'(bus_if.halted), 0);
        check("rst_brk_ce", int'(bus_if.cpu_ce), 0);
        rst = 1'b0;
        tick(18);
        check("cc_wrap", int'(bus_if.cycle_count), 1);

        // Randomized traffic; div_tc only moves when not entering/staying in DIV
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 39) == 0) begin
                nm = int'($urandom_range(0, 3));
                if (nm != 1) bus_if.div_tc = DW'($urandom_range(0, 6));
                bus_if.mode = 2'(nm);
            end
            if ($urandom_range(0, 15) == 0) bus_if.step_req = ~bus_if.step_req;
            bus_if.resume = ($urandom_range(0, 19) == 0);
            bus_if.fetch  = ($urandom_range(0, 2) == 0);
            bus_if.addr   = ($urandom_range(0, 3) == 0) ? bus_if.bp_addr : AW'($urandom);
            if ($urandom_range(0, 99) == 0) bus_if.bp_en = ~bus_if.bp_en;
            tick(1);
        end
        rst = 1'b0;
        bus_if.resume = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Parametrised clock-enable and debug controller that generates the single `cpu_ce` strobe qualifying every CPU register load.
It is the successor to the fixed clkdiv scheme. It adds:
- a programmable divider,
- full-speed, divided, single-step and hold modes,
- an opcode-fetch address breakpoint with halt/resume,
- an enabled-cycle counter.

It sits between the board clock and the 6502 datapath/control. It observes the memory address bus and the opcode-fetch strobe.

Parameters:
- DIV_WIDTH, 17, width of divider counter and `div_tc`.
- ADDR_WIDTH, 16, width of `addr` and `bp_addr`.
- CYC_WIDTH, 32, width of `cycle_count`.
- STEP_SYNC, 2, synchroniser flop stages on `step_req` (≥2).

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0 FULL, 1 DIV, 2 STEP, 3 HOLD.
- div_tc  in  DIV_WIDTH  divider terminal count; DIV period = div_tc+1 clocks.
- step_req  in  1  asynchronous step button level, already debounced.
- resume  in  1  single-cycle pulse; leave breakpoint halt.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_WIDTH  breakpoint opcode-fetch address.
- addr  in  ADDR_WIDTH  CPU memory address bus ({memory_bus_h, memory_bus_l}).
- fetch  in  1  high during an opcode-fetch cycle (IR load cycle).
- cpu_ce  out  1  registered clock enable to all CPU state elements.
- halted  out  1  high while in BRK state.
- bp_hit  out  1  one-cycle pulse when a breakpoint halts or re-hits.
- cycle_count  out  CYC_WIDTH  number of clocks with `cpu_ce`=1.

Behaviour:
- Reset (`rst` high at a clk edge):
  - state = RUN.
  - Divider count = 0.
  - Sync flops and edge register = 0.
  - `cpu_ce`, `halted` and `bp_hit` = 0.
  - `cycle_count` = 0.
  - Reset mid-operation (including from BRK or mid-divide) aborts everything; no `cpu_ce` in the cycle after reset.
- All outputs are registered. `cpu_ce` value for cycle n+1 is computed from inputs and state at cycle n.
- Step edge:
  - `step_req` passes through STEP_SYNC flops, then a rising-edge detect → `step_edge`, one clk wide.
  - Step latency: `cpu_ce` is high for exactly one clk, STEP_SYNC+1 clocks after the first clk edge sampling `step_req` high.
  - Holding `step_req` high produces no further pulses.
- State RUN, by mode:
  - FULL: `cpu_ce`=1 every cycle.
  - DIV: the counter increments each clk. When count == `div_tc`, the counter → 0 and `cpu_ce`=1 next cycle. `div_tc`=0 behaves like FULL.
  - STEP: `cpu_ce` only on `step_edge`.
  - HOLD: `cpu_ce`=0.
  - Any change of `mode` clears the divider count. A `div_tc` change takes effect at the next compare. If the count already exceeds the new `div_tc`, the count wraps at 2^DIV_WIDTH; this is not an error.
  - In RUN, `step_edge` is ignored in FULL, DIV and HOLD.
- Breakpoint:
  - Hit condition: `cpu_ce`=1 & `fetch`=1 & `bp_en`=1 & `addr`==`bp_addr`, all in the same cycle.
  - On a hit, the enabled fetch cycle completes. Next cycle: state = BRK, `halted`=1, `bp_hit`=1 for one cycle, `cpu_ce`=0.
  - Applies in every mode, including STEP.
- State BRK (mode ignored):
  - `cpu_ce`=0, except one pulse per `step_edge`.
  - A stepped fetch that matches again pulses `bp_hit`; the state stays BRK.
  - `resume`=1 → RUN next cycle, `halted`=0, divider count cleared.
  - In FULL, the first `cpu_ce` occurs the cycle after RUN is entered. In DIV, it occurs after `div_tc`+1 clocks.
  - `resume` and `step_edge` in the same cycle: resume wins; no step pulse is issued.
  - Dropping `bp_en` while in BRK does not release the halt.
- `resume` outside BRK: ignored.
- `cycle_count`: +1 on every clk where `cpu_ce`=1; wraps modulo 2^CYC_WIDTH with no flag.

Test Plan:
- Reset/FULL: hold `rst` 3 clk with mode=0, then release → `cpu_ce` 0 during reset, 1 every cycle after; `cycle_count`=10 after 10 enabled clocks.
- DIV: mode=1, `div_tc`=4 → `cpu_ce` high exactly 1 clk in every 5. Switching to mode=0 mid-count gives `cpu_ce`=1 on the next cycle.
- STEP latency: mode=2, STEP_SYNC=2, `step_req` rises and is held 20 clk → exactly one `cpu_ce` pulse, 3 clk after first sampled high. A second rising edge gives a second pulse; `cycle_count`=2.
- Breakpoint: mode=0, `bp_en`=1, `bp_addr`=16'hC003, drive `fetch`=1 with `addr`=C003 in an enabled cycle → next cycle `halted`=1, `bp_hit`=1 for one cycle, `cpu_ce`=0 for 50 clk.
- BRK step/resume: in BRK, a step edge gives one `cpu_ce` and `halted` stays 1. Then `resume` together with a step edge → `halted`=0 next cycle, `cpu_ce`=1 from the following cycle, and no extra step pulse.
- Reset mid-BRK and wrap: assert `rst` while halted → `halted`=0, state RUN. With CYC_WIDTH=4, 17 enabled clocks → `cycle_count`=1.
